// File: rtl/gps_source_arbiter.sv
// Shares one NMEA byte stream between N sentence sources. A source is granted on '$'
// and keeps the grant until '\n', an idle timeout or a length overrun; one byte per 2 cycles.
module gps_source_arbiter #(
    parameter int B       = 8,
    parameter int N       = 2,
    parameter int TIMEOUT = 64,
    parameter int MAX_LEN = 82
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N*B-1:0] src_data,
    input  logic [N-1:0]   src_valid,
    output logic [N-1:0]   src_ready,
    output logic [B-1:0]   data,
    output logic           load,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           abort
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(N);
    localparam logic [B-1:0] DOLLAR  = B'(8'h24);
    localparam logic [B-1:0] NEWLINE = B'(8'h0A);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q;
    logic [IW-1:0] last_q, owner_q;
    logic [LW-1:0] len_q;
    logic [TW-1:0] to_q, to_inc;
    logic          pace_q;
    logic [B-1:0]  data_q;
    logic          load_q, abort_q;
    logic [N-1:0]  grant_q;

    logic [N-1:0]  is_dollar, win_oh;
    logic [IW-1:0] win_idx;
    logic          win_found, own_acc;
    logic [B-1:0]  own_byte;

    always_comb begin
        is_dollar = '0;
        own_byte  = '0;
        for (int i = 0; i < N; i++) begin
            is_dollar[i] = src_valid[i] && (src_data[i*B +: B] == DOLLAR);
            if (IW'(i) == owner_q) own_byte = src_data[i*B +: B];
        end

        // Round-robin: first '$' found starting just after the last owner.
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int k = 1; k <= N; k++) begin
            if (!win_found && is_dollar[(int'(last_q) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last_q) + k) % N);
                win_oh[(int'(last_q) + k) % N] = 1'b1;
            end
        end

        src_ready = '0;
        if (reset && !pace_q) begin
            if (state_q == IDLE) src_ready = (src_valid & ~is_dollar) | win_oh;
            else                 src_ready = src_valid & grant_q;
        end
        own_acc = |(src_ready & grant_q);
        to_inc  = (to_q == TW'(TIMEOUT)) ? to_q : to_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IW'(N - 1);
            owner_q <= '0;
            len_q   <= '0;
            to_q    <= '0;
            pace_q  <= 1'b0;
            data_q  <= '0;
            load_q  <= 1'b0;
            abort_q <= 1'b0;
            grant_q <= '0;
        end else begin
            load_q  <= 1'b0;
            abort_q <= 1'b0;
            pace_q  <= |src_ready;
            case (state_q)
                IDLE: begin
                    if (win_found && !pace_q) begin
                        state_q <= LOCKED;
                        owner_q <= win_idx;
                        grant_q <= win_oh;
                        len_q   <= LW'(1);
                        to_q    <= '0;
                        data_q  <= DOLLAR;
                        load_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (own_acc) begin
                        data_q <= own_byte;
                        load_q <= 1'b1;
                        len_q  <= len_q + 1'b1;
                        to_q   <= '0;
                        if (own_byte == NEWLINE || len_q + 1'b1 == LW'(MAX_LEN)) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            last_q  <= owner_q;
                            len_q   <= '0;
                            abort_q <= (own_byte != NEWLINE);
                        end
                    end else if (to_inc == TW'(TIMEOUT)) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= owner_q;
                        len_q   <= '0;
                        to_q    <= '0;
                        abort_q <= 1'b1;
                    end else begin
                        to_q <= to_inc;
                    end
                end
            endcase
        end
    end

    assign data  = data_q;
    assign load  = load_q;
    assign grant = grant_q;
    assign busy  = (state_q == LOCKED);
    assign abort = abort_q;
endmodule

// File: tb/tb_gps_source_arbiter.sv
// Randomised bench for gps_source_arbiter: per-source byte queues drive the DUT and a
// cycle-level behavioural model of the sentence arbitration rules predicts every output.
module tb_gps_source_arbiter;
    localparam int B       = 8;
    localparam int N       = 2;
    localparam int TIMEOUT = 64;
    localparam int MAX_LEN = 82;
    localparam int VW      = 2*N + B + 3;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N*B-1:0] src_data  = '0;
    logic [N-1:0]   src_valid = '0;
    logic [N-1:0]   src_ready;
    logic [B-1:0]   data;
    logic           load;
    logic [N-1:0]   grant;
    logic           busy;
    logic           abort;

    gps_source_arbiter #(.B(B), .N(N), .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN)) dut (
        .clock(clock), .reset(reset), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .data(data), .load(load), .grant(grant), .busy(busy),
        .abort(abort)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] srcq [N][$];
    bit         jit [N];
    logic [7:0] fwd[$];
    logic [7:0] snt[$];
    int         abort_cnt = 0, abort_cyc = 0, last_load_cyc = 0;
    logic [VW-1:0] obs, expv;
    logic [N-1:0]  last_rdy;

    // Behavioural model state
    bit         m_locked, m_pace, m_load, m_abort;
    int         m_owner, m_last, m_len, m_idle;
    logic [7:0] m_data;

    function automatic logic [7:0] byte_of(int i);
        return src_data[i*B +: B];
    endfunction

    task automatic model_reset();
        m_locked = 0; m_pace = 0; m_load = 0; m_abort = 0;
        m_owner = 0; m_last = N - 1; m_len = 0; m_idle = 0; m_data = 8'h00;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        if (m_pace || !reset) return r;
        if (m_locked) begin
            r[m_owner] = src_valid[m_owner];
            return r;
        end
        for (int i = 0; i < N; i++)
            if (src_valid[i] && byte_of(i) != 8'h24) r[i] = 1'b1;
        for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (src_valid[j] && byte_of(j) == 8'h24) begin
                r[j] = 1'b1;
                break;
            end
        end
        return r;
    endfunction

    task automatic model_edge(input logic [N-1:0] acc);
        m_load = 0; m_abort = 0;
        if (!m_locked) begin
            for (int i = 0; i < N; i++)
                if (acc[i] && byte_of(i) == 8'h24) begin
                    m_locked = 1; m_owner = i; m_len = 1; m_idle = 0;
                    m_data = 8'h24; m_load = 1;
                end
        end else if (acc[m_owner]) begin
            m_data = byte_of(m_owner); m_load = 1; m_len++; m_idle = 0;
            if (m_data == 8'h0A) begin
                m_locked = 0; m_last = m_owner;
            end else if (m_len == MAX_LEN) begin
                m_locked = 0; m_last = m_owner; m_abort = 1;
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_locked = 0; m_last = m_owner; m_abort = 1;
            end
        end
        m_pace = |acc;
    endtask

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g = '0;
        if (m_locked) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic bit pending();
        if (m_locked || m_pace) return 1;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drive(input logic [N-1:0] acc);
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && !acc[i]) continue;
            if (srcq[i].size() > 0 && (!jit[i] || $urandom_range(0, 3) != 0)) begin
                src_valid[i] = 1'b1;
                src_data[i*B +: B] = srcq[i][0];
            end else begin
                src_valid[i] = 1'b0;
            end
        end
    endtask

    // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic tick();
        logic [N-1:0] r;
        #6;
        r = model_ready();
        last_rdy = src_ready;
        model_edge(r);
        @(posedge clock); #1;
        cyc++;
        obs  = {last_rdy, load, data, grant, busy, abort};
        expv = {r, m_load, m_data, m_grant(), m_locked, m_abort};
        if (load) begin fwd.push_back(data); last_load_cyc = cyc; end
        if (abort) begin abort_cnt++; abort_cyc = cyc; end
        for (int i = 0; i < N; i++) if (r[i]) void'(srcq[i].pop_front());
        drive(r);
    endtask

    task automatic push_str(input int i, input string s);
        for (int k = 0; k < s.len(); k++) srcq[i].push_back(s[k]);
    endtask

    task automatic gen_sentence();
        int n, r;
        snt.delete();
        snt.push_back(8'h24); snt.push_back("G"); snt.push_back("P");
        n = $urandom_range(8, 25);
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 36);
            if (r < 26)      snt.push_back(8'(65 + r));
            else if (r < 36) snt.push_back(8'(48 + r - 26));
            else             snt.push_back(",");
        end
        snt.push_back("*");
        snt.push_back(8'(65 + $urandom_range(0, 5)));
        snt.push_back(8'(48 + $urandom_range(0, 9)));
        snt.push_back(8'h0D); snt.push_back(8'h0A);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        src_valid = '0;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        drive('0);
    endtask

    task automatic test_reset();
        model_reset();
        src_valid = 2'b01; src_data = {8'h00, 8'h41};
        #2;
        if ({src_ready, load, data, grant, busy, abort} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {src_ready, load, data, grant, busy, abort});
        end
        checks++;
        src_valid = '0;
        @(posedge clock); #1;
        reset = 1'b1;
        drive('0);
    endtask

    task automatic test_single();
        string s = "$GPZDA,143042.00,25,08,2005,,*6E\r\n";
        int n = 0, prev = -1, gap_bad = 0, bad = 0;
        fwd.delete(); abort_cnt = 0;
        push_str(0, s);
        while (pending() && n < 300) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
            if (load) begin
                if (prev >= 0 && cyc - prev != 2) gap_bad++;
                prev = cyc;
            end
        end
        if (n >= 300) begin errors++; $display("FAIL single_budget got=%0d want<300", n); end
        checks++;
        if (fwd.size() != 34) begin errors++; $display("FAIL single_count got=%0d want=34", fwd.size()); end
        checks++;
        for (int k = 0; k < fwd.size() && k < 34; k++) if (fwd[k] !== s[k]) bad++;
        if (bad != 0) begin errors++; $display("FAIL single_bytes got=%0d bad want=0", bad); end
        checks++;
        if (gap_bad != 0) begin errors++; $display("FAIL single_cadence got=%0d want=0", gap_bad); end
        checks++;
        if (abort_cnt != 0) begin errors++; $display("FAIL single_abort got=%0d want=0", abort_cnt); end
        checks++;
    endtask

    task automatic test_contention();
        logic [7:0] efwd[$];
        int n, len0, bad;
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            fwd.delete(); efwd.delete(); n = 0; bad = 0;
            gen_sentence(); foreach (snt[k]) begin srcq[0].push_back(snt[k]); efwd.push_back(snt[k]); end
            len0 = snt.size();
            gen_sentence(); foreach (snt[k]) begin srcq[1].push_back(snt[k]); efwd.push_back(snt[k]); end
            drive('0);
            while (pending() && n < 400) begin
                tick(); n++;
                if (obs !== expv) begin errors++; $display("FAIL contention cyc=%0d got=%h want=%h", cyc, obs, expv); end
                checks++;
                if (last_rdy[1] && fwd.size() <= len0) bad++;
            end
            if (n >= 400) begin errors++; $display("FAIL contention_budget got=%0d want<400", n); end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL contention_src1_ready got=%0d want=0", bad); end
            checks++;
            bad = (fwd.size() != efwd.size()) ? 1 : 0;
            for (int k = 0; k < fwd.size() && k < efwd.size(); k++) if (fwd[k] !== efwd[k]) bad++;
            if (bad != 0) begin errors++; $display("FAIL contention_order round=%0d got=%0d bad want=0", rnd, bad); end
            checks++;
        end
    endtask

    task automatic test_garbage();
        int n = 0, pre = 0, bad;
        fwd.delete();
        push_str(1, "xx\r\n");
        gen_sentence(); foreach (snt[k]) srcq[1].push_back(snt[k]);
        drive('0);
        while (pending() && n < 300) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL garbage cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
            if (fwd.size() == 0 && last_rdy[1]) pre++;
        end
        if (pre != 4) begin errors++; $display("FAIL garbage_discarded got=%0d want=4", pre); end
        checks++;
        bad = (fwd.size() != snt.size()) ? 1 : 0;
        for (int k = 0; k < fwd.size() && k < snt.size(); k++) if (fwd[k] !== snt[k]) bad++;
        if (bad != 0) begin errors++; $display("FAIL garbage_fwd got=%0d bad want=0", bad); end
        checks++;
    endtask

    task automatic test_timeout();
        int n = 0, loads_at_abort = -1, gap = -1, bad;
        logic [N-1:0] g_at_abort = '1;
        fwd.delete(); abort_cnt = 0;
        push_str(0, "$GPZ");
        drive('0);
        while (pending() && n < 400) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
            if (n == 3) begin
                gen_sentence(); foreach (snt[k]) srcq[1].push_back(snt[k]);
                drive('0);
            end
            if (abort) begin loads_at_abort = fwd.size(); gap = cyc - last_load_cyc; g_at_abort = grant; end
        end
        if (loads_at_abort != 4) begin errors++; $display("FAIL timeout_loads got=%0d want=4", loads_at_abort); end
        checks++;
        if (gap != TIMEOUT) begin errors++; $display("FAIL timeout_gap got=%0d want=%0d", gap, TIMEOUT); end
        checks++;
        if (g_at_abort !== '0) begin errors++; $display("FAIL timeout_grant got=%b want=0", g_at_abort); end
        checks++;
        bad = (fwd.size() != 4 + snt.size()) ? 1 : 0;
        for (int k = 4; k < fwd.size() && k - 4 < snt.size(); k++) if (fwd[k] !== snt[k-4]) bad++;
        if (bad != 0 || abort_cnt != 1) begin errors++; $display("FAIL timeout_next got=%0d bad/%0d aborts want=0/1", bad, abort_cnt); end
        checks++;
    endtask

    task automatic test_overrun();
        int n = 0, bad = 0;
        logic [7:0] sent[$];
        fwd.delete(); abort_cnt = 0;
        sent.push_back(8'h24);
        for (int k = 0; k < 90; k++) sent.push_back(8'(65 + $urandom_range(0, 25)));
        foreach (sent[k]) srcq[0].push_back(sent[k]);
        drive('0);
        while (pending() && n < 600) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL overrun cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
        end
        if (fwd.size() != MAX_LEN) begin errors++; $display("FAIL overrun_count got=%0d want=%0d", fwd.size(), MAX_LEN); end
        checks++;
        for (int k = 0; k < fwd.size() && k < MAX_LEN; k++) if (fwd[k] !== sent[k]) bad++;
        if (bad != 0) begin errors++; $display("FAIL overrun_bytes got=%0d bad want=0", bad); end
        checks++;
        if (abort_cnt != 1 || abort_cyc != last_load_cyc) begin
            errors++; $display("FAIL overrun_abort got=%0d@%0d want=1@%0d", abort_cnt, abort_cyc, last_load_cyc);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int n = 0, bad;
        fwd.delete();
        gen_sentence(); foreach (snt[k]) srcq[0].push_back(snt[k]);
        drive('0);
        while (fwd.size() < 10 && n < 100) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
        end
        reset = 1'b0;
        #1;
        if ({src_ready, load, data, grant, busy, abort} !== '0) begin
            errors++; $display("FAIL reset_mid_clear got=%h want=0", {src_ready, load, data, grant, busy, abort});
        end
        checks++;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        drive('0);
        n = 0;
        while (pending() && n < 200) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL reset_mid_tail cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
        end
        if (fwd.size() != 10) begin errors++; $display("FAIL reset_mid_noresume got=%0d want=10", fwd.size()); end
        checks++;
        gen_sentence(); foreach (snt[k]) srcq[0].push_back(snt[k]);
        drive('0);
        n = 0;
        while (pending() && n < 200) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL reset_mid_fresh cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
        end
        bad = (fwd.size() != 10 + snt.size()) ? 1 : 0;
        for (int k = 10; k < fwd.size() && k - 10 < snt.size(); k++) if (fwd[k] !== snt[k-10]) bad++;
        if (bad != 0) begin errors++; $display("FAIL reset_mid_restart got=%0d bad want=0", bad); end
        checks++;
    endtask

    task automatic test_random();
        int n = 0, total = 0;
        fwd.delete(); abort_cnt = 0;
        for (int i = 0; i < N; i++) jit[i] = 1;
        for (int i = 0; i < N; i++)
            for (int rnd = 0; rnd < 3; rnd++) begin
                int g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) srcq[i].push_back(8'(97 + $urandom_range(0, 25)));
                gen_sentence(); foreach (snt[k]) srcq[i].push_back(snt[k]);
                total += snt.size();
            end
        drive('0);
        while (pending() && n < 4000) begin
            tick(); n++;
            if (obs !== expv) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expv); end
            checks++;
        end
        if (n >= 4000) begin errors++; $display("FAIL random_budget got=%0d want<4000", n); end
        checks++;
        if (fwd.size() != total || abort_cnt != 0) begin
            errors++; $display("FAIL random_totals got=%0d/%0d want=%0d/0", fwd.size(), abort_cnt, total);
        end
        checks++;
        for (int i = 0; i < N; i++) jit[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) jit[i] = 0;
        test_reset();
        test_single();
        test_contention();
        test_garbage();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
